// File: rtl/rr_request_encoder_if.sv
// Request/grant bundle between the smart-home device requesters and the
// round-robin encoder that drives the 4-to-16 decoder.
interface rr_request_encoder_if;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic        valid;
  logic        timeout;
  logic        busy;

  // Requester side: raises requests and completion strobes, watches the grant.
  modport master (
    output req, done,
    input  sel, valid, timeout, busy
  );

  // Encoder side.
  modport slave (
    input  req, done,
    output sel, valid, timeout, busy
  );
endinterface

// File: rtl/rr_request_encoder.sv
// Round-robin request encoder: grants one of 16 devices at a time, holds the
// grant until done or timeout, then inserts one all-off cycle before re-arbitrating.
module rr_request_encoder #(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_request_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [3:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic [3:0]       winner;
  logic             any_req;

  // Scan from the highest offset down so the set bit closest to ptr is the
  // last assignment and therefore wins.
  always_comb begin
    winner  = ptr_q;
    any_req = |bus.req;
    for (int i = 15; i >= 0; i--) begin
      if (bus.req[ptr_q + 4'(i)]) begin
        winner = ptr_q + 4'(i);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d   = winner;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        // done takes precedence, so a completion on the last cycle is not a timeout.
        if (bus.done) begin
          valid_d = 1'b0;
          ptr_d   = sel_q + 4'd1;
          state_d = GAP;
        end else if (cnt_q == LAST_CNT) begin
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          ptr_d     = sel_q + 4'd1;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_rr_request_encoder.sv
// Directed bench for rr_request_encoder: stimulus pushes expected grants into a
// queue, a negedge monitor pops and checks each grant as the encoder presents it.
module tb_rr_request_encoder;

  localparam int TIMEOUT = 8;

  typedef struct {
    logic [3:0] sel;
    int         len;   // expected cycles with valid high; 0 = ended by reset
    logic       to;    // expected timeout pulse on release
  } exp_t;

  logic clk;
  logic rst;

  rr_request_encoder_if bus ();

  rr_request_encoder #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int i = 0;
    while (bus.valid !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    check("wait_valid", {31'd0, bus.valid}, 32'd1);
  endtask

  // Called just after the grant edge: hold done low for k edges, then pulse it.
  task automatic run_grant(input int k);
    repeat (k) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  task automatic expect_grant(input logic [3:0] sel, input int len, input logic to);
    exp_t e;
    e.sel = sel;
    e.len = len;
    e.to  = to;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor
  logic in_grant = 1'b0;
  int   hold     = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      if (!in_grant) begin
        in_grant = 1'b1;
        hold     = 1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_grant: got sel=%0d, expected no grant (t=%0t)", bus.sel, $time);
          cur.sel = bus.sel;
          cur.len = 0;
          cur.to  = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          check("grant_sel", {28'd0, bus.sel}, {28'd0, cur.sel});
          check("grant_busy", {31'd0, bus.busy}, 32'd1);
        end
      end else begin
        hold++;
        check("grant_sel_stable", {28'd0, bus.sel}, {28'd0, cur.sel});
      end
    end else if (in_grant) begin
      in_grant = 1'b0;
      if (cur.len != 0) check("grant_len", hold, cur.len);
      check("release_timeout", {31'd0, bus.timeout}, {31'd0, cur.to});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;
    #1;
    check("rst_sel",     {28'd0, bus.sel},     32'd0);
    check("rst_valid",   {31'd0, bus.valid},   32'd0);
    check("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    check("rst_busy",    {31'd0, bus.busy},    32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_valid", {31'd0, bus.valid}, 32'd0);
    end
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Single requester: grant, done, gap, regrant of the same device
    expect_grant(4'd5, 1, 1'b0);
    bus.req = 16'h0020;
    wait_valid(4);
    run_grant(0);
    check("single_released", {31'd0, bus.valid}, 32'd0);
    expect_grant(4'd5, 3, 1'b0);
    wait_valid(4);
    run_grant(2);
    bus.req = '0;
    repeat (3) tick();

    // Async reset: outputs clear before any edge, pointer returns to 0
    #2 rst = 1'b1;
    #1;
    check("async_rst_sel",   {28'd0, bus.sel},   32'd0);
    check("async_rst_valid", {31'd0, bus.valid}, 32'd0);
    check("async_rst_busy",  {31'd0, bus.busy},  32'd0);
    tick();
    rst = 1'b0;

    // Round-robin wrap 0 -> 15 -> 0
    expect_grant(4'd0, 1, 1'b0);
    expect_grant(4'd15, 1, 1'b0);
    expect_grant(4'd0, 1, 1'b0);
    bus.req = 16'h8001;
    for (int i = 0; i < 3; i++) begin
      wait_valid(4);
      run_grant(0);
    end
    bus.req = '0;
    repeat (3) tick();

    // Timeout release, then next grant goes to the following device
    expect_grant(4'd3, TIMEOUT, 1'b1);
    bus.req = 16'h0008;
    wait_valid(4);
    expect_grant(4'd4, TIMEOUT, 1'b0);
    bus.req = 16'h0018;
    repeat (TIMEOUT) tick();
    check("to_valid", {31'd0, bus.valid},   32'd0);
    check("to_pulse", {31'd0, bus.timeout}, 32'd1);
    check("gap_busy", {31'd0, bus.busy},    32'd1);
    tick();
    check("to_pulse_end", {31'd0, bus.timeout}, 32'd0);
    check("idle_after_gap_busy", {31'd0, bus.busy}, 32'd0);

    // done on the final allowed cycle: release without timeout
    wait_valid(4);
    run_grant(TIMEOUT - 1);
    bus.req = '0;
    repeat (3) tick();

    // Request dropped mid-grant keeps the grant; reset mid-grant kills it
    expect_grant(4'd2, 0, 1'b0);
    bus.req = 16'h0004;
    wait_valid(4);
    bus.req = '0;
    repeat (3) tick();
    check("hold_valid", {31'd0, bus.valid}, 32'd1);
    check("hold_sel",   {28'd0, bus.sel},   32'd2);
    #2 rst = 1'b1;
    #1;
    check("midgrant_rst_valid",   {31'd0, bus.valid},   32'd0);
    check("midgrant_rst_sel",     {28'd0, bus.sel},     32'd0);
    check("midgrant_rst_busy",    {31'd0, bus.busy},    32'd0);
    check("midgrant_rst_timeout", {31'd0, bus.timeout}, 32'd0);
    tick();
    rst = 1'b0;

    expect_grant(4'd1, 1, 1'b0);
    bus.req = 16'h0006;
    wait_valid(4);
    run_grant(0);
    bus.req = '0;
    repeat (4) tick();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("no_open_grant", {31'd0, in_grant}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_request_encoder.md
Name: rr_request_encoder

Overview:
- Round-robin arbiter/encoder directly upstream of the 4-to-16 decoder in the smart-home controller.
- Samples 16 device service requests and grants one at a time.
- Presents the winner as a registered 4-bit index `sel` (feeds the decoder `in`) qualified by `valid`.
- Holds each grant until the serviced device signals `done` or a timeout expires, then rotates priority.

Parameters:
- TIMEOUT, 8, max cycles a grant is held without `done` (legal range 2..15).
- CNT_W, 4, width of hold counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  request vector; bit i = device i wants service; level-sensitive.
- done  input  1  service-complete strobe from granted device; meaningful only in GRANT.
- sel  output  4  granted device index, registered; feeds decoder `in`.
- valid  output  1  high while `sel` is a live grant; downstream gates decoder output with it.
- timeout  output  1  one-cycle pulse when a grant is released by timeout.
- busy  output  1  high in GRANT or GAP state.

Behaviour:
- Reset (async, immediate on rst=1):
  - sel=0, valid=0, timeout=0, busy=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
  - Reset asserted mid-grant drops `valid` without waiting for a clock edge.
- States: IDLE, GRANT, GAP.
- IDLE:
  - At each rising edge, if req != 0, select the first set bit scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod-16 wrap).
  - On that same edge: register sel=winner, valid=1, counter=0, go to GRANT.
  - Latency: req sampled at edge k gives valid=1 immediately after edge k.
  - If req=0, stay in IDLE with valid=0; sel holds its last value.
- GRANT:
  - sel and valid are stable; req is not re-sampled.
  - Deassertion of the granted req bit does not end the grant. Only `done` or timeout ends it.
  - If done=1 at an edge: valid=0, ptr=sel+1 mod 16 (15 wraps to 0), go to GAP.
  - Else if counter==TIMEOUT-1: valid=0, timeout=1 for exactly one cycle, ptr=sel+1 mod 16, go to GAP.
  - Else: counter increments.
  - The grant therefore lasts at most TIMEOUT cycles.
  - If done and timeout occur on the same edge, done wins: no timeout pulse.
- GAP:
  - Exactly one cycle with valid=0, guaranteeing an all-off decoder slot between grants.
  - Then unconditionally go to IDLE.
  - A new grant is therefore issued at the earliest 2 edges after release.
- done is ignored in IDLE and GAP.
- timeout is 0 in all states except the single pulse cycle.
- A single requester held continuously is regranted after each GAP. No starvation: worst-case wait is 15 grants.
- Fully synchronous except reset. No combinational path from req or done to any output.

Test Plan:
- Reset: assert rst mid-simulation -> sel=0, valid=0, busy=0, timeout=0 immediately. Release rst, req=0 for 5 cycles -> valid stays 0.
- Single request: req=16'h0020 -> after 1 edge sel=5, valid=1. Pulse done=1 for 1 cycle -> valid=0 next edge. valid=0 for the GAP cycle, then sel=5, valid=1 again (req still high).
- Round-robin wrap: from reset, req=16'h8001 -> grant sel=0. done -> grant sel=15. done -> grant sel=0. Confirms the 15->0 pointer wrap.
- Timeout: TIMEOUT=8, req=16'h0008, done held 0 -> valid=1 with sel=3 for 8 cycles. timeout=1 on the release cycle only. Next grant with req=16'h0018 is sel=4.
- Done/timeout collision: done=1 on the cycle counter==TIMEOUT-1 -> release occurs, timeout stays 0.
- Mid-grant changes: grant sel=2, then set req=0 -> valid stays 1 until done/timeout. Assert rst during GRANT -> valid falls asynchronously. After reset, ptr=0 so req=16'h0006 grants sel=1.
